iir_in_stage: RTL and testbench

- Upstream stage of the first-order IIR filter (myiir).
- Accepts bursty 9-bit two's-complement samples from the source with a ready/valid handshake and buffers them in a small FIFO.
- Releases them to the filter's DIN/VIN inputs as single-cycle valid pulses, with a programmable minimum spacing.
- Protects the look-ahead filter pipeline from back-to-back bursts and flags protocol overruns.

---
 rtl/iir_in_stage_if.sv | 31 +++
 rtl/iir_in_stage.sv | 134 +++++++++++++
 tb/tb_iir_in_stage.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/iir_in_stage_if.sv
// iir_in_stage_if
//   Bundles the sample-side handshake and the filter-side outputs of
//   iir_in_stage. The signal names match the original port names.
//   master : source side (drives DIN/VIN/GAP/FLUSH, observes the rest)
//   slave  : iir_in_stage itself
//   Signals: DIN[NB], VIN, RDY, GAP[4], FLUSH, DOUT[NB], VOUT,
//            CNT[log2(DEPTH)+1], OVF
interface iir_in_stage_if #(
  parameter int NB    = 9,
  parameter int DEPTH = 8
) ();
  logic [NB-1:0]            DIN;
  logic                     VIN;
  logic                     RDY;
  logic [3:0]               GAP;
  logic                     FLUSH;
  logic [NB-1:0]            DOUT;
  logic                     VOUT;
  logic [$clog2(DEPTH):0]   CNT;
  logic                     OVF;

  modport master (
    output DIN, VIN, GAP, FLUSH,
    input  RDY, DOUT, VOUT, CNT, OVF
  );

  modport slave (
    input  DIN, VIN, GAP, FLUSH,
    output RDY, DOUT, VOUT, CNT, OVF
  );
endinterface

// File: rtl/iir_in_stage.sv
// iir_in_stage
//   Input buffer ahead of the first-order IIR filter. Accepts bursty
//   two's-complement samples on a ready/valid handshake, stores them in a
//   DEPTH-entry FIFO and releases them as one-cycle VOUT pulses separated by
//   at least GAP idle cycles. OVF is a sticky flag for writes while full.
//
//   Ports:
//     CLK    system clock, rising edge
//     RST_n  asynchronous active-low reset
//     bus    iir_in_stage_if.slave:
//              DIN/VIN/RDY  source handshake (RDY = occupancy < DEPTH)
//              GAP          minimum idle cycles between VOUT pulses
//              FLUSH        synchronous clear of FIFO, gap counter and OVF
//              DOUT/VOUT    registered sample and valid pulse to the filter
//              CNT          FIFO occupancy 0..DEPTH
//              OVF          sticky overrun flag
//
//   Build option: define IIR_IN_CLIP_EN to saturate samples to [-CLIP, +CLIP]
//   on the write side; otherwise samples pass bit-exact and CLIP is unused.
module iir_in_stage #(
  parameter int NB    = 9,
  parameter int DEPTH = 8,
  parameter int CLIP  = 240
) (
  input  logic         CLK,
  input  logic         RST_n,
  iir_in_stage_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("iir_in_stage: DEPTH must be a power of 2, at least 2");
  end
  if (CLIP < 0 || CLIP > (2 ** (NB - 1)) - 1) begin : g_bad_clip
    $error("iir_in_stage: CLIP must fit a positive NB-bit value");
  end

  logic [NB-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q,  cnt_d;
  logic [3:0]    gap_q,  gap_d;
  logic [NB-1:0] dout_q, dout_d;
  logic          vout_q, vout_d;
  logic          ovf_q,  ovf_d;

  logic          rdy;
  logic          wr;
  logic          rd;
  logic [NB-1:0] wr_data;

`ifdef IIR_IN_CLIP_EN
  localparam logic signed [NB-1:0] CLIP_POS = NB'(CLIP);
  localparam logic signed [NB-1:0] CLIP_NEG = NB'(-CLIP);

  always_comb begin
    wr_data = bus.DIN;
    if ($signed(bus.DIN) > CLIP_POS)      wr_data = CLIP_POS;
    else if ($signed(bus.DIN) < CLIP_NEG) wr_data = CLIP_NEG;
  end
`else
  assign wr_data = bus.DIN;
`endif

  // Both write and read decisions use pre-edge occupancy, so a read on the
  // same edge never frees room for a write into a full FIFO, and a write into
  // an empty FIFO is never read on the same edge.
  assign rdy = (cnt_q < FULL_CNT);
  assign wr  = bus.VIN && rdy && !bus.FLUSH;
  assign rd  = (cnt_q != '0) && (gap_q == '0) && !bus.FLUSH;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    gap_d  = gap_q;
    dout_d = dout_q;
    vout_d = 1'b0;
    ovf_d  = ovf_q;
    if (bus.FLUSH) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      gap_d  = '0;
      ovf_d  = 1'b0;
    end else begin
      if (wr) wptr_d = wptr_q + 1'b1;
      if (bus.VIN && !rdy) ovf_d = 1'b1;
      if (rd) begin
        dout_d = mem_q[rptr_q];
        vout_d = 1'b1;
        rptr_d = rptr_q + 1'b1;
        gap_d  = bus.GAP;
      end else if (gap_q != '0) begin
        gap_d = gap_q - 1'b1;
      end
      cnt_d = cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      gap_q  <= '0;
      dout_q <= '0;
      vout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      gap_q  <= gap_d;
      dout_q <= dout_d;
      vout_q <= vout_d;
      ovf_q  <= ovf_d;
    end
  end

  // Storage needs no reset: contents are only visible through the pointers.
  always_ff @(posedge CLK) begin
    if (wr) mem_q[wptr_q] <= wr_data;
  end

  assign bus.RDY  = rdy;
  assign bus.CNT  = cnt_q;
  assign bus.DOUT = dout_q;
  assign bus.VOUT = vout_q;
  assign bus.OVF  = ovf_q;

endmodule

// File: tb/tb_iir_in_stage.sv
module tb_iir_in_stage;
  localparam int NB    = 9;
  localparam int DEPTH = 8;
  localparam int CLIP  = 240;

  logic CLK = 1'b0;
  logic RST_n;

  iir_in_stage_if #(.NB(NB), .DEPTH(DEPTH)) bus ();

  iir_in_stage #(.NB(NB), .DEPTH(DEPTH), .CLIP(CLIP)) dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: a sample queue plus the edge index at which the next
  // release is allowed.
  logic [NB-1:0] mq[$];
  logic [NB-1:0] m_dout;
  logic          m_vout;
  logic          m_ovf;
  int            edge_n;
  int            next_ok;

  function automatic logic [NB-1:0] model_store(input logic [NB-1:0] d);
`ifdef IIR_IN_CLIP_EN
    int v;
    v = int'($signed(d));
    if (v > CLIP)  v = CLIP;
    if (v < -CLIP) v = -CLIP;
    return NB'(v);
`else
    return d;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout  = '0;
    m_vout  = 1'b0;
    m_ovf   = 1'b0;
    next_ok = 0;
  endtask

  task automatic check_outputs();
    chk("VOUT", 32'(bus.VOUT), 32'(m_vout));
    chk("DOUT", 32'(bus.DOUT), 32'(m_dout));
    chk("CNT",  32'(bus.CNT),  32'(mq.size()));
    chk("OVF",  32'(bus.OVF),  32'(m_ovf));
  endtask

  // One clock: drive inputs, check RDY before the edge, advance the model,
  // then check registered outputs 1ns after the edge.
  task automatic step(input logic [NB-1:0] din, input logic vin,
                      input logic [3:0] gap, input logic flush);
    int   pre;
    logic rd, wr;
    bus.DIN   = din;
    bus.VIN   = vin;
    bus.GAP   = gap;
    bus.FLUSH = flush;
    #1;
    pre = mq.size();
    chk("RDY", 32'(bus.RDY), 32'(pre < DEPTH));
    rd = !flush && (pre > 0) && (edge_n >= next_ok);
    wr = !flush && vin && (pre < DEPTH);
    @(posedge CLK);
    #1;
    if (flush) begin
      mq.delete();
      m_vout  = 1'b0;
      m_ovf   = 1'b0;
      next_ok = 0;
    end else begin
      m_vout = 1'b0;
      if (rd) begin
        m_dout  = mq.pop_front();
        m_vout  = 1'b1;
        next_ok = edge_n + int'(gap) + 1;
      end
      if (wr) mq.push_back(model_store(din));
      else if (vin) m_ovf = 1'b1;
    end
    edge_n++;
    check_outputs();
  endtask

  task automatic idle(input int n, input logic [3:0] gap);
    for (int i = 0; i < n; i++) step('0, 1'b0, gap, 1'b0);
  endtask

  initial begin
    bus.DIN   = '0;
    bus.VIN   = 1'b0;
    bus.GAP   = '0;
    bus.FLUSH = 1'b0;
    edge_n    = 0;
    model_reset();

    // Cold reset
    RST_n = 1'b1;
    #2 RST_n = 1'b0;
    #1;
    check_outputs();
    chk("RDY_in_reset", 32'(bus.RDY), 32'd1);
    @(posedge CLK);
    @(posedge CLK);
    #1 RST_n = 1'b1;

    // Single sample at cycle 10
    idle(9, 4'd0);
    step(9'h055, 1'b1, 4'd0, 1'b0);
    idle(5, 4'd0);

    // Burst of 6 with GAP=3
    for (int i = 1; i <= 6; i++) step(NB'(i), 1'b1, 4'd3, 1'b0);
    idle(30, 4'd3);

    // Overflow: 10 samples with GAP=15
    for (int i = 10; i <= 19; i++) step(NB'(i), 1'b1, 4'd15, 1'b0);
    idle(140, 4'd15);

    // Flush mid-burst with a coincident VIN, then a fresh sample
    for (int i = 0; i < 5; i++) step(NB'(32 + i), 1'b1, 4'd15, 1'b0);
    step(9'h033, 1'b1, 4'd15, 1'b1);
    idle(3, 4'd15);
    step(9'h1F0, 1'b1, 4'd15, 1'b0);
    idle(20, 4'd15);

    // Async reset with data pending and OVF set
    for (int i = 0; i < 10; i++) step(NB'(64 + i), 1'b1, 4'd15, 1'b0);
    chk("OVF_before_reset", 32'(bus.OVF), 32'd1);
    bus.VIN = 1'b0;
    #3 RST_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("RDY_after_async_reset", 32'(bus.RDY), 32'd1);
    #1 RST_n = 1'b1;
    step(9'h0AA, 1'b1, 4'd0, 1'b0);
    step(9'h155, 1'b1, 4'd0, 1'b0);
    idle(6, 4'd0);

    // Clip corner values (saturated only when the clip option is built in)
    step(NB'(250), 1'b1, 4'd0, 1'b0);
    step(9'h100,   1'b1, 4'd0, 1'b0);
    step(NB'(100), 1'b1, 4'd0, 1'b0);
    step(NB'(-241), 1'b1, 4'd0, 1'b0);
    idle(6, 4'd0);

    // Randomized traffic with changing GAP and occasional FLUSH
    for (int i = 0; i < 1500; i++) begin
      logic [NB-1:0] d;
      logic          v, f;
      logic [3:0]    g;
      d = NB'($urandom);
      v = ($urandom_range(0, 99) < 60);
      g = (i % 300 < 150) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 6));
      f = ($urandom_range(0, 99) < 2);
      step(d, v, g, f);
    end
    idle(120, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
